// File: rtl/vga_axil_arbiter.sv
// 2:1 round-robin AXI4-Lite arbiter sharing one downstream slave; one outstanding transaction.
// Optional response timeout with SLVERR reply is enabled by defining VGA_AXIL_ARB_TIMEOUT_EN.
module vga_axil_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned STRB_W        = DATA_W / 8
) (
   input  logic              clk,
   input  logic              srst,
   // upstream port 0
   input  logic [ADDR_W-1:0] s0_araddr,
   input  logic              s0_arvalid,
   output logic              s0_arready,
   output logic [DATA_W-1:0] s0_rdata,
   output logic [1:0]        s0_rresp,
   output logic              s0_rvalid,
   input  logic              s0_rready,
   input  logic [ADDR_W-1:0] s0_awaddr,
   input  logic              s0_awvalid,
   output logic              s0_awready,
   input  logic [DATA_W-1:0] s0_wdata,
   input  logic [STRB_W-1:0] s0_wstrb,
   input  logic              s0_wvalid,
   output logic              s0_wready,
   output logic [1:0]        s0_bresp,
   output logic              s0_bvalid,
   input  logic              s0_bready,
   // upstream port 1
   input  logic [ADDR_W-1:0] s1_araddr,
   input  logic              s1_arvalid,
   output logic              s1_arready,
   output logic [DATA_W-1:0] s1_rdata,
   output logic [1:0]        s1_rresp,
   output logic              s1_rvalid,
   input  logic              s1_rready,
   input  logic [ADDR_W-1:0] s1_awaddr,
   input  logic              s1_awvalid,
   output logic              s1_awready,
   input  logic [DATA_W-1:0] s1_wdata,
   input  logic [STRB_W-1:0] s1_wstrb,
   input  logic              s1_wvalid,
   output logic              s1_wready,
   output logic [1:0]        s1_bresp,
   output logic              s1_bvalid,
   input  logic              s1_bready,
   // downstream master
   output logic [ADDR_W-1:0] m_araddr,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic              m_rvalid,
   output logic              m_rready,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [DATA_W-1:0] m_wdata,
   output logic [STRB_W-1:0] m_wstrb,
   output logic              m_wvalid,
   input  logic              m_wready,
   input  logic [1:0]        m_bresp,
   input  logic              m_bvalid,
   output logic              m_bready,
   // status
   output logic              grant,
   output logic              busy,
   output logic              timeout_pulse
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD_ADDR = 3'd1;
   localparam logic [2:0] ST_RD_DATA = 3'd2;
   localparam logic [2:0] ST_WR_ADDR = 3'd3;
   localparam logic [2:0] ST_WR_RESP = 3'd4;
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
   localparam logic [2:0] ST_ERR_RESP = 3'd5;
   localparam logic [2:0] ST_DRAIN    = 3'd6;
   localparam int unsigned CNT_W =
      ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
`endif

   logic [2:0] state_q, state_d;
   logic       grant_q, grant_d;
   logic       rr_ptr_q, rr_ptr_d;
   logic       aw_done_q, aw_done_d;
   logic       w_done_q, w_done_d;
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
   logic             is_wr_q, is_wr_d;
   logic [CNT_W-1:0] tcnt_q, tcnt_d;
   logic             pulse_q, pulse_d;
`endif

   logic [1:0] rd_req, wr_req, req;
   logic       pick;

   assign rd_req = {s1_arvalid, s0_arvalid};
   assign wr_req = {s1_awvalid | s1_wvalid, s0_awvalid | s0_wvalid};
   assign req    = rd_req | wr_req;

   // Granted port's master-driven signals
   logic [ADDR_W-1:0] g_araddr, g_awaddr;
   logic [DATA_W-1:0] g_wdata;
   logic [STRB_W-1:0] g_wstrb;
   logic              g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;

   assign g_araddr  = grant_q ? s1_araddr  : s0_araddr;
   assign g_arvalid = grant_q ? s1_arvalid : s0_arvalid;
   assign g_rready  = grant_q ? s1_rready  : s0_rready;
   assign g_awaddr  = grant_q ? s1_awaddr  : s0_awaddr;
   assign g_awvalid = grant_q ? s1_awvalid : s0_awvalid;
   assign g_wdata   = grant_q ? s1_wdata   : s0_wdata;
   assign g_wstrb   = grant_q ? s1_wstrb   : s0_wstrb;
   assign g_wvalid  = grant_q ? s1_wvalid  : s0_wvalid;
   assign g_bready  = grant_q ? s1_bready  : s0_bready;

   // Responses/readies destined for the granted port
   logic              up_arready, up_rvalid, up_awready, up_wready, up_bvalid;
   logic [DATA_W-1:0] up_rdata;
   logic [1:0]        up_rresp, up_bresp;

   // Channel forwarding, gated by state and per-channel completion
   always_comb begin
      m_araddr   = '0;
      m_arvalid  = 1'b0;
      m_rready   = 1'b0;
      m_awaddr   = '0;
      m_awvalid  = 1'b0;
      m_wdata    = '0;
      m_wstrb    = '0;
      m_wvalid   = 1'b0;
      m_bready   = 1'b0;
      up_arready = 1'b0;
      up_rvalid  = 1'b0;
      up_rdata   = '0;
      up_rresp   = '0;
      up_awready = 1'b0;
      up_wready  = 1'b0;
      up_bvalid  = 1'b0;
      up_bresp   = '0;
      case (state_q)
         ST_RD_ADDR: begin
            m_araddr   = g_araddr;
            m_arvalid  = g_arvalid;
            up_arready = m_arready;
         end
         ST_RD_DATA: begin
            m_rready  = g_rready;
            up_rvalid = m_rvalid;
            up_rdata  = m_rdata;
            up_rresp  = m_rresp;
         end
         ST_WR_ADDR: begin
            if (!aw_done_q) begin
               m_awaddr   = g_awaddr;
               m_awvalid  = g_awvalid;
               up_awready = m_awready;
            end
            if (!w_done_q) begin
               m_wdata   = g_wdata;
               m_wstrb   = g_wstrb;
               m_wvalid  = g_wvalid;
               up_wready = m_wready;
            end
         end
         ST_WR_RESP: begin
            m_bready  = g_bready;
            up_bvalid = m_bvalid;
            up_bresp  = m_bresp;
         end
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
         ST_ERR_RESP: begin
            if (is_wr_q) begin
               up_bvalid = 1'b1;
               up_bresp  = RESP_SLVERR;
            end else begin
               up_rvalid = 1'b1;
               up_rresp  = RESP_SLVERR;
            end
         end
         ST_DRAIN: begin
            m_bready = is_wr_q;
            m_rready = !is_wr_q;
         end
`endif
         default: ;
      endcase
   end

   // Route to granted port; the other port sees all zeros
   always_comb begin
      s0_arready = !grant_q & up_arready;
      s0_rvalid  = !grant_q & up_rvalid;
      s0_rdata   = grant_q ? '0 : up_rdata;
      s0_rresp   = grant_q ? '0 : up_rresp;
      s0_awready = !grant_q & up_awready;
      s0_wready  = !grant_q & up_wready;
      s0_bvalid  = !grant_q & up_bvalid;
      s0_bresp   = grant_q ? '0 : up_bresp;
      s1_arready = grant_q & up_arready;
      s1_rvalid  = grant_q & up_rvalid;
      s1_rdata   = grant_q ? up_rdata : '0;
      s1_rresp   = grant_q ? up_rresp : '0;
      s1_awready = grant_q & up_awready;
      s1_wready  = grant_q & up_wready;
      s1_bvalid  = grant_q & up_bvalid;
      s1_bresp   = grant_q ? up_bresp : '0;
   end

   logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
   assign ar_hs = m_arvalid & m_arready;
   assign r_hs  = m_rvalid  & m_rready;
   assign aw_hs = m_awvalid & m_awready;
   assign w_hs  = m_wvalid  & m_wready;
   assign b_hs  = m_bvalid  & m_bready;

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      pick      = (req[0] && req[1]) ? rr_ptr_q : req[1];
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
      is_wr_d = is_wr_q;
      tcnt_d  = tcnt_q;
      pulse_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req != 2'b00) begin
               grant_d = pick;
               state_d = wr_req[pick] ? ST_WR_ADDR : ST_RD_ADDR;
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
               is_wr_d = wr_req[pick];
`endif
            end
         end
         ST_RD_ADDR: begin
            if (ar_hs) begin
               state_d = ST_RD_DATA;
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
               tcnt_d = '0;
`endif
            end
         end
         ST_RD_DATA: begin
            if (r_hs) begin
               state_d  = ST_IDLE;
               rr_ptr_d = ~grant_q;
            end
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
            else if (!m_rvalid) begin
               if (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d = ST_ERR_RESP;
                  pulse_d = 1'b1;
               end else begin
                  tcnt_d = tcnt_q + CNT_W'(1);
               end
            end
`endif
         end
         ST_WR_ADDR: begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
               state_d   = ST_WR_RESP;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
               tcnt_d = '0;
`endif
            end
         end
         ST_WR_RESP: begin
            if (b_hs) begin
               state_d  = ST_IDLE;
               rr_ptr_d = ~grant_q;
            end
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
            else if (!m_bvalid) begin
               if (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d = ST_ERR_RESP;
                  pulse_d = 1'b1;
               end else begin
                  tcnt_d = tcnt_q + CNT_W'(1);
               end
            end
`endif
         end
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
         ST_ERR_RESP: begin
            if (is_wr_q ? g_bready : g_rready) state_d = ST_DRAIN;
         end
         // The late downstream response is swallowed here
         ST_DRAIN: begin
            if (r_hs || b_hs) begin
               state_d  = ST_IDLE;
               rr_ptr_d = ~grant_q;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q   <= ST_IDLE;
         grant_q   <= 1'b0;
         rr_ptr_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
         is_wr_q <= 1'b0;
         tcnt_q  <= '0;
         pulse_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
         is_wr_q <= is_wr_d;
         tcnt_q  <= tcnt_d;
         pulse_q <= pulse_d;
`endif
      end
   end

   assign grant = grant_q;
   assign busy  = (state_q != ST_IDLE);
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
   assign timeout_pulse = pulse_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
   assign timeout_pulse      = 1'b0;
`endif

endmodule

// File: tb/tb_vga_axil_arbiter.sv
// Directed bench for vga_axil_arbiter: reads, writes, round-robin, reset abort and timeout.
module tb_vga_axil_arbiter;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   logic clk = 1'b0;
   logic srst;
   logic [ADDR_W-1:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr, m_araddr, m_awaddr;
   logic              s0_arvalid, s1_arvalid, s0_arready, s1_arready, m_arvalid, m_arready;
   logic [DATA_W-1:0] s0_rdata, s1_rdata, m_rdata, s0_wdata, s1_wdata, m_wdata;
   logic [1:0]        s0_rresp, s1_rresp, m_rresp, s0_bresp, s1_bresp, m_bresp;
   logic              s0_rvalid, s1_rvalid, m_rvalid, s0_rready, s1_rready, m_rready;
   logic              s0_awvalid, s1_awvalid, m_awvalid, s0_awready, s1_awready, m_awready;
   logic [STRB_W-1:0] s0_wstrb, s1_wstrb, m_wstrb;
   logic              s0_wvalid, s1_wvalid, m_wvalid, s0_wready, s1_wready, m_wready;
   logic              s0_bvalid, s1_bvalid, m_bvalid, s0_bready, s1_bready, m_bready;
   logic              grant, busy, timeout_pulse;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vga_axil_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .srst(srst),
      .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
      .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
      .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
      .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
      .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
      .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
      .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
      .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
      .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
      .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      s0_araddr = '0; s0_arvalid = 1'b0; s0_rready = 1'b0;
      s0_awaddr = '0; s0_awvalid = 1'b0; s0_wdata = '0; s0_wstrb = '0; s0_wvalid = 1'b0;
      s0_bready = 1'b0;
      s1_araddr = '0; s1_arvalid = 1'b0; s1_rready = 1'b0;
      s1_awaddr = '0; s1_awvalid = 1'b0; s1_wdata = '0; s1_wstrb = '0; s1_wvalid = 1'b0;
      s1_bready = 1'b0;
      m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_bresp = '0; m_bvalid = 1'b0;
   endtask

   task automatic apply_reset;
      clear_inputs();
      srst = 1'b1;
      tick();
      tick();
      srst = 1'b0;
   endtask

   task automatic test_reset;
      clear_inputs();
      srst = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, grant, timeout_pulse, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
           s0_arready, s0_rvalid, s0_awready, s0_wready, s0_bvalid,
           s1_arready, s1_rvalid, s1_awready, s1_wready, s1_bvalid} !== 18'h0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b want 0", {busy, grant, timeout_pulse, m_arvalid,
                  m_rready, m_awvalid, m_wvalid, m_bready, s0_arready, s0_rvalid, s0_awready,
                  s0_wready, s0_bvalid, s1_arready, s1_rvalid, s1_awready, s1_wready, s1_bvalid});
      end
      checks++;
      if ({m_araddr, m_awaddr, m_wdata, m_wstrb, s0_rdata, s0_rresp, s0_bresp,
           s1_rdata, s1_rresp, s1_bresp} !== '0) begin
         failures++;
         $display("FAIL reset_data: got %h want 0", {m_araddr, m_awaddr, m_wdata, m_wstrb,
                  s0_rdata, s0_rresp, s0_bresp, s1_rdata, s1_rresp, s1_bresp});
      end
      srst = 1'b0;
   endtask

   task automatic test_single_read;
      clear_inputs();
      s0_araddr = 32'h4; s0_arvalid = 1'b1; m_arready = 1'b1;
      #1;
      checks++;
      if ({s0_arready, m_arvalid, busy} !== 3'b000) begin
         failures++;
         $display("FAIL rd_idle_no_ready: got %b want 000", {s0_arready, m_arvalid, busy});
      end
      tick();
      checks++;
      if ({busy, grant, m_arvalid, m_araddr, s0_arready, s1_arready} !== {3'b101, 32'h4, 2'b10}) begin
         failures++;
         $display("FAIL rd_addr: got %h want %h", {busy, grant, m_arvalid, m_araddr, s0_arready,
                  s1_arready}, {3'b101, 32'h4, 2'b10});
      end
      tick();
      s0_arvalid = 1'b0; s0_araddr = '0; m_arready = 1'b0;
      m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00; s0_rready = 1'b1;
      #1;
      checks++;
      if ({s0_rvalid, s0_rdata, s0_rresp, m_rready} !== {1'b1, 32'hDEADBEEF, 2'b00, 1'b1}) begin
         failures++;
         $display("FAIL rd_data: got %h want %h", {s0_rvalid, s0_rdata, s0_rresp, m_rready},
                  {1'b1, 32'hDEADBEEF, 2'b00, 1'b1});
      end
      checks++;
      if ({s1_rvalid, s1_rdata, s1_rresp, s1_arready, grant} !== '0) begin
         failures++;
         $display("FAIL rd_s1_quiet: got %h want 0", {s1_rvalid, s1_rdata, s1_rresp, s1_arready, grant});
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if ({busy, s0_rvalid, m_arvalid} !== 3'b000) begin
         failures++;
         $display("FAIL rd_back_idle: got %b want 000", {busy, s0_rvalid, m_arvalid});
      end
   endtask

   task automatic test_round_robin;
      apply_reset();
      s0_araddr = 32'h100; s1_araddr = 32'h200; s0_arvalid = 1'b1; s1_arvalid = 1'b1;
      tick();
      checks++;
      if ({grant, m_araddr} !== {1'b0, 32'h100}) begin
         failures++;
         $display("FAIL rr_first_s0: got %h want %h", {grant, m_araddr}, {1'b0, 32'h100});
      end
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0; s0_arvalid = 1'b0;
      m_rvalid = 1'b1; m_rdata = 32'hA0A0_A0A0; s0_rready = 1'b1; s1_rready = 1'b1;
      #1;
      checks++;
      if ({s0_rvalid, s0_rdata, s1_rvalid} !== {1'b1, 32'hA0A0A0A0, 1'b0}) begin
         failures++;
         $display("FAIL rr_first_data: got %h want %h", {s0_rvalid, s0_rdata, s1_rvalid},
                  {1'b1, 32'hA0A0A0A0, 1'b0});
      end
      s0_araddr = 32'h104; s0_arvalid = 1'b1;
      tick();
      m_rvalid = 1'b0; m_arready = 1'b1;
      #1;
      checks++;
      if ({busy, s0_arready, s1_arready, m_arvalid} !== 4'b0000) begin
         failures++;
         $display("FAIL rr_idle_gap: got %b want 0000", {busy, s0_arready, s1_arready, m_arvalid});
      end
      tick();
      checks++;
      if ({grant, m_araddr, s1_arready, s0_arready} !== {1'b1, 32'h200, 2'b10}) begin
         failures++;
         $display("FAIL rr_second_s1: got %h want %h", {grant, m_araddr, s1_arready, s0_arready},
                  {1'b1, 32'h200, 2'b10});
      end
      tick();
      m_arready = 1'b0; s1_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hB1B1_B1B1;
      #1;
      checks++;
      if ({s1_rvalid, s1_rdata, s0_rvalid, s0_rdata} !== {1'b1, 32'hB1B1B1B1, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL rr_second_data: got %h want %h", {s1_rvalid, s1_rdata, s0_rvalid, s0_rdata},
                  {1'b1, 32'hB1B1B1B1, 1'b0, 32'h0});
      end
      tick();
      m_rvalid = 1'b0;
      tick();
      checks++;
      if ({grant, m_araddr} !== {1'b0, 32'h104}) begin
         failures++;
         $display("FAIL rr_third_s0: got %h want %h", {grant, m_araddr}, {1'b0, 32'h104});
      end
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0; s0_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_00C2;
      #1;
      checks++;
      if ({s0_rvalid, s0_rdata} !== {1'b1, 32'hC2}) begin
         failures++;
         $display("FAIL rr_third_data: got %h want %h", {s0_rvalid, s0_rdata}, {1'b1, 32'hC2});
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_write_split;
      clear_inputs();
      s1_awaddr = 32'h10; s1_awvalid = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
      tick();
      checks++;
      if ({busy, grant, m_awvalid, m_awaddr, s1_awready, m_wvalid, s0_awready, s0_wready}
          !== {3'b111, 32'h10, 4'b1000}) begin
         failures++;
         $display("FAIL wr_aw_fwd: got %h want %h", {busy, grant, m_awvalid, m_awaddr, s1_awready,
                  m_wvalid, s0_awready, s0_wready}, {3'b111, 32'h10, 4'b1000});
      end
      tick();
      s1_awaddr = 32'h14;
      #1;
      checks++;
      if ({m_awvalid, s1_awready, m_awaddr, s1_bvalid, busy} !== {2'b00, 32'h0, 2'b01}) begin
         failures++;
         $display("FAIL wr_aw_done_masked: got %h want %h", {m_awvalid, s1_awready, m_awaddr,
                  s1_bvalid, busy}, {2'b00, 32'h0, 2'b01});
      end
      tick();
      s1_wdata = 32'hCAFE_F00D; s1_wstrb = 4'hF; s1_wvalid = 1'b1;
      #1;
      checks++;
      if ({m_wvalid, m_wdata, m_wstrb, s1_wready, s0_wready} !== {1'b1, 32'hCAFEF00D, 4'hF, 2'b10}) begin
         failures++;
         $display("FAIL wr_w_fwd: got %h want %h", {m_wvalid, m_wdata, m_wstrb, s1_wready, s0_wready},
                  {1'b1, 32'hCAFEF00D, 4'hF, 2'b10});
      end
      tick();
      s1_awvalid = 1'b0; s1_wvalid = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00; s1_bready = 1'b1;
      #1;
      checks++;
      if ({s1_bvalid, s1_bresp, m_bready, s0_bvalid, m_wvalid, m_awvalid} !== 7'b1001000) begin
         failures++;
         $display("FAIL wr_bresp: got %b want 1001000", {s1_bvalid, s1_bresp, m_bready, s0_bvalid,
                  m_wvalid, m_awvalid});
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if ({busy, s1_bvalid} !== 2'b00) begin
         failures++;
         $display("FAIL wr_back_idle: got %b want 00", {busy, s1_bvalid});
      end
   endtask

   task automatic test_write_priority;
      clear_inputs();
      s0_araddr = 32'h20; s0_arvalid = 1'b1;
      s0_awaddr = 32'h24; s0_awvalid = 1'b1;
      s0_wdata = 32'h55AA; s0_wstrb = 4'h3; s0_wvalid = 1'b1;
      tick();
      checks++;
      if ({grant, m_arvalid, m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb}
          !== {3'b001, 32'h24, 1'b1, 32'h55AA, 4'h3}) begin
         failures++;
         $display("FAIL prio_write_first: got %h want %h", {grant, m_arvalid, m_awvalid, m_awaddr,
                  m_wvalid, m_wdata, m_wstrb}, {3'b001, 32'h24, 1'b1, 32'h55AA, 4'h3});
      end
      m_awready = 1'b1; m_wready = 1'b1;
      #1;
      checks++;
      if ({s0_awready, s0_wready, s0_arready} !== 3'b110) begin
         failures++;
         $display("FAIL prio_readies: got %b want 110", {s0_awready, s0_wready, s0_arready});
      end
      tick();
      s0_awvalid = 1'b0; s0_wvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
      m_bvalid = 1'b1; m_bresp = 2'b00; s0_bready = 1'b1;
      #1;
      checks++;
      if ({s0_bvalid, s0_bresp, m_bready} !== 4'b1001) begin
         failures++;
         $display("FAIL prio_bresp: got %b want 1001", {s0_bvalid, s0_bresp, m_bready});
      end
      tick();
      m_bvalid = 1'b0; s0_bready = 1'b0;
      #1;
      checks++;
      if ({busy, s0_arready, m_arvalid} !== 3'b000) begin
         failures++;
         $display("FAIL prio_gap: got %b want 000", {busy, s0_arready, m_arvalid});
      end
      tick();
      checks++;
      if ({busy, grant, m_arvalid, m_araddr} !== {3'b101, 32'h20}) begin
         failures++;
         $display("FAIL prio_read_next: got %h want %h", {busy, grant, m_arvalid, m_araddr},
                  {3'b101, 32'h20});
      end
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0; s0_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h600D; s0_rready = 1'b1;
      #1;
      checks++;
      if ({s0_rvalid, s0_rdata, s0_rresp} !== {1'b1, 32'h600D, 2'b00}) begin
         failures++;
         $display("FAIL prio_read_data: got %h want %h", {s0_rvalid, s0_rdata, s0_rresp},
                  {1'b1, 32'h600D, 2'b00});
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_reset_mid;
      clear_inputs();
      s1_araddr = 32'h30; s1_arvalid = 1'b1;
      tick();
      m_arready = 1'b1;
      tick();
      s1_arvalid = 1'b0; m_arready = 1'b0; s1_rready = 1'b1;
      #1;
      checks++;
      if ({busy, grant, m_rready} !== 3'b111) begin
         failures++;
         $display("FAIL rstmid_pre: got %b want 111", {busy, grant, m_rready});
      end
      srst = 1'b1; s1_rready = 1'b0;
      tick();
      m_rvalid = 1'b1; m_rdata = 32'hBAD; s1_rready = 1'b1;
      #1;
      checks++;
      if ({busy, grant, m_rready, s1_rvalid, s1_rdata, s0_rvalid} !== '0) begin
         failures++;
         $display("FAIL rstmid_abandon: got %h want 0", {busy, grant, m_rready, s1_rvalid,
                  s1_rdata, s0_rvalid});
      end
      srst = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      s1_araddr = 32'h34; s1_arvalid = 1'b1;
      tick();
      checks++;
      if ({grant, m_arvalid, m_araddr} !== {2'b11, 32'h34}) begin
         failures++;
         $display("FAIL rstmid_fresh_addr: got %h want %h", {grant, m_arvalid, m_araddr},
                  {2'b11, 32'h34});
      end
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0; s1_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1111;
      #1;
      checks++;
      if ({s1_rvalid, s1_rdata, s1_rresp} !== {1'b1, 32'h1111, 2'b00}) begin
         failures++;
         $display("FAIL rstmid_fresh_data: got %h want %h", {s1_rvalid, s1_rdata, s1_rresp},
                  {1'b1, 32'h1111, 2'b00});
      end
      tick();
      clear_inputs();
   endtask

`ifdef VGA_AXIL_ARB_TIMEOUT_EN
   task automatic test_timeout;
      clear_inputs();
      s0_araddr = 32'h40; s0_arvalid = 1'b1;
      tick();
      m_arready = 1'b1;
      tick();
      s0_arvalid = 1'b0; m_arready = 1'b0;
      repeat (7) tick();
      checks++;
      if ({busy, s0_rvalid, timeout_pulse} !== 3'b100) begin
         failures++;
         $display("FAIL to_before: got %b want 100", {busy, s0_rvalid, timeout_pulse});
      end
      tick();
      checks++;
      if ({s0_rvalid, s0_rresp, s0_rdata, timeout_pulse, m_rready} !== {3'b110, 32'h0, 2'b10}) begin
         failures++;
         $display("FAIL to_slverr: got %h want %h", {s0_rvalid, s0_rresp, s0_rdata, timeout_pulse,
                  m_rready}, {3'b110, 32'h0, 2'b10});
      end
      tick();
      checks++;
      if ({s0_rvalid, timeout_pulse} !== 2'b10) begin
         failures++;
         $display("FAIL to_pulse_once: got %b want 10", {s0_rvalid, timeout_pulse});
      end
      s0_rready = 1'b1;
      tick();
      s0_rready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1234;
      #1;
      checks++;
      if ({busy, m_rready, s0_rvalid, s0_rdata, s1_rvalid} !== {3'b110, 32'h0, 1'b0}) begin
         failures++;
         $display("FAIL to_drain: got %h want %h", {busy, m_rready, s0_rvalid, s0_rdata, s1_rvalid},
                  {3'b110, 32'h0, 1'b0});
      end
      tick();
      m_rvalid = 1'b0; m_rdata = '0;
      s1_araddr = 32'h44; s1_arvalid = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL to_back_idle: got %b want 0", busy);
      end
      tick();
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0; s1_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h7777; s1_rready = 1'b1;
      #1;
      checks++;
      if ({grant, s1_rvalid, s1_rdata, s1_rresp} !== {2'b11, 32'h7777, 2'b00}) begin
         failures++;
         $display("FAIL to_next_read: got %h want %h", {grant, s1_rvalid, s1_rdata, s1_rresp},
                  {2'b11, 32'h7777, 2'b00});
      end
      tick();
      clear_inputs();
   endtask
`else
   task automatic test_no_timeout;
      clear_inputs();
      s0_araddr = 32'h40; s0_arvalid = 1'b1;
      tick();
      m_arready = 1'b1;
      tick();
      s0_arvalid = 1'b0; m_arready = 1'b0; s0_rready = 1'b1;
      repeat (20) tick();
      checks++;
      if ({busy, s0_rvalid, timeout_pulse, m_rready} !== 4'b1001) begin
         failures++;
         $display("FAIL nto_waiting: got %b want 1001", {busy, s0_rvalid, timeout_pulse, m_rready});
      end
      m_rvalid = 1'b1; m_rdata = 32'h4242;
      #1;
      checks++;
      if ({s0_rvalid, s0_rdata, s0_rresp} !== {1'b1, 32'h4242, 2'b00}) begin
         failures++;
         $display("FAIL nto_late_data: got %h want %h", {s0_rvalid, s0_rdata, s0_rresp},
                  {1'b1, 32'h4242, 2'b00});
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if ({busy, timeout_pulse} !== 2'b00) begin
         failures++;
         $display("FAIL nto_idle: got %b want 00", {busy, timeout_pulse});
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      srst = 1'b1;
      clear_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_split();
      test_write_priority();
      test_reset_mid();
`ifdef VGA_AXIL_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
